// File: rtl/mult_out_serializer.sv
// mult_out_serializer: downstream stage of the shift-add multiplier.
// Captures a 32-bit product on each rising edge of din_rdy, buffers products
// in a FIFO_DEPTH-word circular FIFO and streams them out MSB byte first over
// a valid/ready byte handshake. A product arriving with the FIFO full (and no
// pop in the same cycle) is dropped and flagged by a one-cycle overflow pulse.
// Optional feature: define SER_CHECKSUM_EN to append one XOR checksum byte
// (din_1^din_2^din_3^din_4) after the four data bytes of every word.
module mult_out_serializer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_rdy,
    input  logic [7:0] din_1,
    input  logic [7:0] din_2,
    input  logic [7:0] din_3,
    input  logic [7:0] din_4,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef SER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, SEND, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
`endif

    state_t        state_q;
    logic          din_rdy_q;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic [31:0]   shreg_q;
    logic [1:0]    idx_q;
    logic          dout_valid_q;
    logic          overflow_q;
`ifdef SER_CHECKSUM_EN
    logic [7:0]    chk_q;
`endif

    logic [31:0] in_word;
    logic [31:0] head;
    logic        capture;
    logic        full;
    logic        pop;
    logic        push;
    logic        accept;

    assign in_word = {din_1, din_2, din_3, din_4};
    assign head    = mem_q[rd_ptr_q];
    assign capture = din_rdy & ~din_rdy_q;
    assign full    = (count_q == FULL_CNT);
    // The FSM only enters LOAD with a non-empty FIFO, so LOAD always pops.
    assign pop     = (state_q == LOAD);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push    = capture & (~full | pop);
    assign accept  = dout_valid_q & dout_ready;

    assign dout       = shreg_q[31:24];
    assign dout_valid = dout_valid_q;
    assign fifo_full  = full;
    assign overflow   = overflow_q;

    // Next occupancy after this cycle's push and pop.
    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; count_q guarantees stale entries are never read.
        if (push) begin
            mem_q[wr_ptr_q] <= in_word;
        end
    end

    // Capture edge detect, FIFO pointers, occupancy and overflow pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_rdy_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            din_rdy_q  <= din_rdy;
            count_q    <= count_d;
            overflow_q <= capture & ~push;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Serializer FSM: load head word, shift out bytes MSB first, optional checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            idx_q        <= '0;
            dout_valid_q <= 1'b0;
`ifdef SER_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    shreg_q      <= head;
                    idx_q        <= '0;
                    dout_valid_q <= 1'b1;
                    state_q      <= SEND;
`ifdef SER_CHECKSUM_EN
                    chk_q        <= head[31:24] ^ head[23:16] ^ head[15:8] ^ head[7:0];
`endif
                end
                SEND: begin
                    if (accept) begin
                        if (idx_q == 2'd3) begin
`ifdef SER_CHECKSUM_EN
                            shreg_q <= {chk_q, 24'h000000};
                            state_q <= CHK;
`else
                            dout_valid_q <= 1'b0;
                            state_q      <= (count_d != '0) ? LOAD : IDLE;
`endif
                        end else begin
                            shreg_q <= {shreg_q[23:0], 8'h00};
                            idx_q   <= idx_q + 2'd1;
                        end
                    end
                end
`ifdef SER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        dout_valid_q <= 1'b0;
                        state_q      <= (count_d != '0) ? LOAD : IDLE;
                    end
                end
`endif
                default: begin
                    state_q      <= IDLE;
                    dout_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_out_serializer.sv
// Self-checking bench for mult_out_serializer. A transaction-level model
// (queues of words and bytes) predicts the outputs every cycle; directed
// tests add literal expectations on byte order, latency, stalls and overflow.
// Honours SER_CHECKSUM_EN to expect the extra XOR byte per word.
module tb_mult_out_serializer;

    localparam int DEPTH = 4;
`ifdef SER_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       din_rdy;
    logic [7:0] din_1, din_2, din_3, din_4;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       fifo_full;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mult_out_serializer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_rdy    (din_rdy),
        .din_1      (din_1),
        .din_2      (din_2),
        .din_3      (din_3),
        .din_4      (din_4),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_fifo[$];
    logic [7:0]  m_cur[$];
    bit          m_pend;
    bit          m_prev_rdy;
    bit          m_ovf;
    bit          m_idle_before;
    bit          m_do_pop;
    bit          m_cap;
    int          m_size_before;
    logic [31:0] m_w;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_fifo.delete();
            m_cur.delete();
            m_pend     = 1'b0;
            m_prev_rdy = 1'b0;
            m_ovf      = 1'b0;
        end else begin
            m_idle_before = (m_cur.size() == 0) && !m_pend;
            m_size_before = m_fifo.size();
            m_do_pop      = m_pend;
            m_cap         = din_rdy && !m_prev_rdy;
            m_prev_rdy    = din_rdy;
            m_ovf         = 1'b0;
            m_w           = '0;
            if (m_do_pop) m_w = m_fifo.pop_front();
            if (m_cap) begin
                if (m_size_before < DEPTH || m_do_pop) m_fifo.push_back({din_1, din_2, din_3, din_4});
                else m_ovf = 1'b1;
            end
            if (m_cur.size() > 0 && dout_ready) begin
                void'(m_cur.pop_front());
                if (m_cur.size() == 0) m_pend = (m_fifo.size() > 0);
            end
            if (m_do_pop) begin
                m_pend = 1'b0;
                m_cur.push_back(m_w[31:24]);
                m_cur.push_back(m_w[23:16]);
                m_cur.push_back(m_w[15:8]);
                m_cur.push_back(m_w[7:0]);
`ifdef SER_CHECKSUM_EN
                m_cur.push_back(m_w[31:24] ^ m_w[23:16] ^ m_w[15:8] ^ m_w[7:0]);
`endif
            end else if (m_idle_before && m_size_before > 0) begin
                m_pend = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid", {31'd0, dout_valid}, {31'd0, m_cur.size() > 0});
            if (m_cur.size() > 0) check("dout", {24'd0, dout}, {24'd0, m_cur[0]});
            check("fifo_full", {31'd0, fifo_full}, {31'd0, m_fifo.size() == DEPTH});
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    // ---------------- logging for directed checks ----------------
    int         cyc = 0;
    logic [7:0] log_b[$];
    int         log_c[$];
    int         ov_cnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst && dout_valid && dout_ready) begin
            log_b.push_back(dout);
            log_c.push_back(cyc);
        end
        if (overflow) ov_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_log();
        log_b.delete();
        log_c.delete();
        ov_cnt = 0;
    endtask

    task automatic capture(input logic [31:0] w);
        {din_1, din_2, din_3, din_4} = w;
        din_rdy = 1'b1;
        step(1);
        din_rdy = 1'b0;
        step(1);
    endtask

    logic [31:0] exp_w[$];

    // Compare the byte log with the words in exp_w, MSB first (+checksum).
    task automatic check_log(input string name);
        int k;
        logic [7:0] e;
        k = 0;
        check({name, "_len"}, 32'(log_b.size()), 32'(exp_w.size() * NB));
        foreach (exp_w[i]) begin
            for (int j = 0; j < NB; j++) begin
                if (j < 4) e = exp_w[i][31 - 8 * j -: 8];
                else e = exp_w[i][31:24] ^ exp_w[i][23:16] ^ exp_w[i][15:8] ^ exp_w[i][7:0];
                if (k < log_b.size()) check(name, {24'd0, log_b[k]}, {24'd0, e});
                k++;
            end
        end
    endtask

    logic [7:0]  t1_exp [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    logic [31:0] w3 [6] = '{32'hA1B2C3D4, 32'h0F1E2D3C, 32'h55AA33CC,
                            32'h01020304, 32'hF0E0D0C0, 32'hDEADBEEF};
    int  cap_c;
    bit  found;

    initial begin
        rst = 1'b1;
        din_rdy = 1'b0;
        dout_ready = 1'b0;
        {din_1, din_2, din_3, din_4} = '0;
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        step(2);
        check("rst_dout", {24'd0, dout}, 32'h00);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_full", {31'd0, fifo_full}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b1;
        step(2);

        // Test 1: single pulse, latency and byte order.
        clear_log();
        dout_ready = 1'b1;
        cap_c = cyc + 1;
        capture(32'h12345678);
        step(8);
        check("t1_len", 32'(log_b.size()), 32'(NB));
        for (int j = 0; j < NB; j++) begin
            if (j < log_b.size()) check("t1_byte", {24'd0, log_b[j]}, {24'd0, t1_exp[j]});
            if (j < log_c.size()) check("t1_cycle", 32'(log_c[j] - cap_c), 32'(2 + j));
        end
        check("t1_idle_after", {31'd0, dout_valid}, 32'd0);

        // Test 2: din_rdy held high for 10 cycles -> one word.
        clear_log();
        exp_w = {32'hCAFEF00D};
        {din_1, din_2, din_3, din_4} = 32'hCAFEF00D;
        din_rdy = 1'b1;
        step(10);
        din_rdy = 1'b0;
        step(10);
        check_log("t2_bytes");

        // Test 3: fill FIFO with consumer stalled, then overflow.
        clear_log();
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) capture(w3[i]);
        check("t3_full", {31'd0, fifo_full}, 32'd1);
        check("t3_no_ovf", 32'(ov_cnt), 32'd0);
        check("t3_valid", {31'd0, dout_valid}, 32'd1);
        check("t3_head_byte", {24'd0, dout}, 32'hA1);
        capture(w3[5]);
        step(2);
        check("t3_ovf_pulse", 32'(ov_cnt), 32'd1);
        check("t3_still_full", {31'd0, fifo_full}, 32'd1);
        dout_ready = 1'b1;
        step(6 * NB + 10);
        exp_w = {w3[0], w3[1], w3[2], w3[3], w3[4]};
        check_log("t3_bytes");

        // Test 4: stall for 7 cycles after byte 1.
        clear_log();
        capture(32'h89ABCDEF);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (dout_valid && dout == 8'h89) found = 1'b1;
            else step(1);
        end
        check("t4_first_byte_seen", {31'd0, found}, 32'd1);
        step(1);
        dout_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            check("t4_hold_valid", {31'd0, dout_valid}, 32'd1);
            check("t4_hold_dout", {24'd0, dout}, 32'hAB);
        end
        dout_ready = 1'b1;
        step(NB + 4);
        exp_w = {32'h89ABCDEF};
        check_log("t4_bytes");

        // Test 5: asynchronous reset during byte 2 with 2 words queued.
        clear_log();
        dout_ready = 1'b0;
        capture(32'h11223344);
        capture(32'h55667788);
        capture(32'h99AABBCC);
        dout_ready = 1'b1;
        step(1);
        dout_ready = 1'b0;
        check("t5_byte2", {24'd0, dout}, 32'h22);
        #1 rst = 1'b0;
        #1;
        check("t5_rst_dout", {24'd0, dout}, 32'h00);
        check("t5_rst_valid", {31'd0, dout_valid}, 32'd0);
        check("t5_rst_full", {31'd0, fifo_full}, 32'd0);
        check("t5_rst_ovf", {31'd0, overflow}, 32'd0);
        step(2);
        rst = 1'b1;
        clear_log();
        dout_ready = 1'b1;
        step(15);
        check("t5_silent_after_rst", 32'(log_b.size()), 32'd0);
        capture(32'h13579BDF);
        step(NB + 4);
        exp_w = {32'h13579BDF};
        check_log("t5_new_word");

        // Test 6: back-to-back words, one bubble between words.
        clear_log();
        dout_ready = 1'b1;
        capture(32'h0A0B0C0D);
        capture(32'h1A1B1C1D);
        capture(32'h2A2B2C2D);
        step(20);
        exp_w = {32'h0A0B0C0D, 32'h1A1B1C1D, 32'h2A2B2C2D};
        check_log("t6_bytes");
        for (int i = 1; i < log_c.size(); i++) begin
            check("t6_spacing", 32'(log_c[i] - log_c[i-1]), (i % NB == 0) ? 32'd2 : 32'd1);
        end

        // Test 7: sustained overload with varying phase (model-checked).
        for (int g = 0; g < 6; g++) begin
            for (int i = 0; i < 6; i++) begin
                dout_ready = ($urandom_range(0, 3) != 0);
                capture($urandom);
            end
            dout_ready = 1'b1;
            step(g);
        end
        dout_ready = 1'b1;
        step(8 * NB + 20);
        check("t7_drained", {31'd0, dout_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mult_out_serializer.md
# mult_out_serializer

Downstream stage of the shift-add multiplier: captures each 32-bit product the multiplier presents as four bytes plus a ready strobe, buffers products in a small FIFO, and streams them out one byte at a time, MSB first, over a valid/ready byte handshake. It decouples the multiplier's one-shot result strobe from a byte-wide consumer that may stall.

## Interface
Parameters:
- FIFO_DEPTH, 4: product words buffered; power of two, ≥2.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous active-low reset.
- din_rdy  in  1  multiplier result-ready level, driven by the multiplier's dout_rdy.
- din_1  in  8  product bits [31:24].
- din_2  in  8  product bits [23:16].
- din_3  in  8  product bits [15:8].
- din_4  in  8  product bits [7:0].
- dout  out  8  output byte.
- dout_valid  out  1  dout holds a valid byte.
- dout_ready  in  1  consumer accepts the byte this cycle.
- fifo_full  out  1  FIFO holds FIFO_DEPTH words.
- overflow  out  1  one-cycle pulse: a product was dropped.

## Operation
- Capture: register din_rdy into din_rdy_q. A capture event is din_rdy==1 && din_rdy_q==0 (rising edge). One capture per rising edge; a held-high din_rdy captures once.
- On capture, the word {din_1,din_2,din_3,din_4} is pushed to the FIFO if it is not full, or if a pop occurs in the same cycle. Otherwise the word is discarded and overflow pulses high for that cycle.
- FIFO: circular buffer with wrapping read/write pointers of log2(FIFO_DEPTH) bits, plus a count of log2(FIFO_DEPTH)+1 bits. fifo_full = (count==FIFO_DEPTH).
- FSM states:
  - IDLE: if count>0, go to LOAD.
  - LOAD: pop the head word into a 32-bit shift register; byte index = 0; go to SEND.
  - SEND: dout = shreg[31:24]; dout_valid=1. On dout_valid && dout_ready, shift shreg left by 8 and increment the index.
    - After byte 3 is accepted: go to CHK if enabled; else go to LOAD if count>0 (counted after that cycle's push), else IDLE.
  - CHK (only with macro): see Configuration.
- Stall: while dout_valid && !dout_ready, dout and dout_valid hold stable. Captures continue into the FIFO.
- Byte order per word: din_1, din_2, din_3, din_4.

## Timing
- Reset values: dout=8'h00, dout_valid=0, fifo_full=0, overflow=0; FSM=IDLE, pointers/count=0, din_rdy_q=0.
- Reset is asynchronous. Asserting rst mid-word aborts the word, clears the FIFO, and drops any partial output. No output is glitched high after reset.
- Latency, idle and empty case: capture at edge N; the word is in the FIFO after edge N; LOAD at edge N+1; dout_valid=1 after edge N+2.
- Throughput: 4 bytes per word with dout_ready held high, plus one LOAD bubble cycle between consecutive words (5 cycles per word; 6 with checksum).
- overflow is combinationally registered: it asserts for exactly the cycle after the dropped capture edge.
- A capture and a LOAD pop in the same cycle with count==FIFO_DEPTH: the push succeeds, count is unchanged, and overflow stays 0.

## Configuration
- SER_CHECKSUM_EN defined:
  - After byte 3 is accepted, the FSM enters CHK and presents dout = din_1^din_2^din_3^din_4 of the current word, with dout_valid=1 under the same hold rules.
  - On acceptance, the FSM goes to LOAD or IDLE as above.
- SER_CHECKSUM_EN undefined: no CHK state and no XOR logic; 4 bytes per word.

## Test plan
- Reset, then pulse din_rdy for one cycle with bytes 12,34,56,78 and dout_ready=1 -> dout_valid rises 2 cycles later; dout = 0x12,0x34,0x56,0x78 on consecutive cycles (plus 0x08 with SER_CHECKSUM_EN); then dout_valid=0.
- Hold din_rdy high for 10 cycles -> exactly one word is emitted.
- Hold dout_ready=0 and issue 5 capture edges with FIFO_DEPTH=4 -> first word in shreg, 4 words in FIFO, fifo_full=1, no overflow. A 6th edge -> overflow pulses for one cycle and that word never appears.
- Stall mid-word: hold dout_ready=0 after byte 1 for 7 cycles -> dout stays at byte 2 with valid=1; then the remaining bytes follow in order.
- Assert rst during byte 2 with 2 words queued -> all outputs go to reset values immediately; after release, no bytes are emitted until a new capture.
- Back-to-back: 3 words with dout_ready=1 -> 12 bytes in order, with exactly one valid=0 bubble cycle between words.
